// File: rtl/rng_range.sv
// rtl/rng_range.sv - bounded uniform random value in [lo, hi] from a free-running LFSR stream
module rng_range #(
  parameter int MAX_TRIES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] rng_in,
  input  logic        req,
  input  logic [15:0] lo,
  input  logic [15:0] hi,
  input  logic        ack,
  output logic        busy,
  output logic        valid,
  output logic [15:0] value,
  output logic        err,
  output logic [3:0]  tries
);

  typedef enum logic [1:0] {S_IDLE, S_MASK, S_DRAW, S_HOLD} state_t;

  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  state_t      state, state_next;
  logic [15:0] lo_r, range_r, mask_r;
  logic        err_r;
  logic [3:0]  cnt;
  logic [15:0] smear, cand;
  logic        accept, exhausted, trivial;

  // Cumulative smear: smallest 2^k-1 covering range_r
  always_comb begin
    smear = range_r;
    smear = smear | (smear >> 1);
    smear = smear | (smear >> 2);
    smear = smear | (smear >> 4);
    smear = smear | (smear >> 8);
  end

  assign cand      = rng_in & mask_r;
  assign accept    = (cand <= range_r);
  assign exhausted = (cnt == LAST_TRY);
  assign trivial   = err_r || (range_r == 16'd0);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req) state_next = S_MASK;
      S_MASK: state_next = trivial ? S_HOLD : S_DRAW;
      S_DRAW: if (accept || exhausted) state_next = S_HOLD;
      S_HOLD: if (ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    valid = (state == S_HOLD);
  end

  // value/err/tries are written only on the transition into HOLD
  always_ff @(posedge clock) begin
    if (reset) begin
      lo_r    <= 16'd0;
      range_r <= 16'd0;
      mask_r  <= 16'd0;
      err_r   <= 1'b0;
      cnt     <= 4'd0;
      value   <= 16'd0;
      err     <= 1'b0;
      tries   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            lo_r    <= lo;
            range_r <= hi - lo;
            err_r   <= (hi < lo);
            cnt     <= 4'd0;
          end
        end
        S_MASK: begin
          mask_r <= smear;
          if (trivial) begin
            value <= lo_r;
            err   <= err_r;
            tries <= 4'd0;
          end
        end
        S_DRAW: begin
          if (accept) begin
            value <= lo_r + cand;
            err   <= err_r;
            tries <= cnt;
          end else begin
            cnt <= cnt + 4'd1;
            if (exhausted) begin
              // cand <= 2*range_r+1, so the folded offset stays inside the range
              value <= lo_r + (cand - range_r - 16'd1);
              err   <= err_r;
              tries <= cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_range.sv
// tb/tb_rng_range.sv - randomized self-checking bench for rng_range against a behavioural model
module tb_rng_range;

  localparam int MAX_TRIES = 8;

  logic        clock = 1'b0;
  logic        reset, req, ack;
  logic [15:0] rng_in, lo, hi;
  logic        busy, valid, err;
  logic [15:0] value;
  logic [3:0]  tries;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] seq [16];
  logic [15:0] m_value;
  logic        m_err;
  int          m_tries, m_lat;

  always #5 clock = ~clock;

  rng_range #(.MAX_TRIES(MAX_TRIES)) dut (
    .clock(clock), .reset(reset), .rng_in(rng_in), .req(req), .lo(lo), .hi(hi),
    .ack(ack), .busy(busy), .valid(valid), .value(value), .err(err), .tries(tries)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: seq[i] is the rng_in value seen on the i-th draw cycle
  task automatic model(input logic [15:0] l, input logic [15:0] h);
    logic [15:0] span, mask, cand;
    span  = h - l;
    m_err = (h < l);
    if (m_err || span == 16'd0) begin
      m_value = l; m_tries = 0; m_lat = 2;
      return;
    end
    mask = 16'd0;
    while (mask < span) mask = (mask << 1) | 16'd1;
    cand = 16'd0;
    for (int i = 0; i < MAX_TRIES; i++) begin
      cand = seq[i] & mask;
      if (cand <= span) begin
        m_value = l + cand; m_tries = i; m_lat = 3 + i;
        return;
      end
    end
    m_value = l + (cand - span - 16'd1);
    m_tries = MAX_TRIES;
    m_lat   = 2 + MAX_TRIES;
  endtask

  task automatic fill_seq(input logic [15:0] v);
    for (int i = 0; i < 16; i++) seq[i] = v;
  endtask

  task automatic run_txn(input string tag, input logic [15:0] l, input logic [15:0] h,
                         input bit poke_req, input bit ack_req);
    int lat;
    int hold_cycles;
    model(l, h);
    @(negedge clock);
    req = 1'b1; lo = l; hi = h; rng_in = 16'($urandom);
    @(negedge clock);
    req = 1'b0; lo = 16'($urandom); hi = 16'($urandom); rng_in = 16'($urandom);
    check_eq({tag, ".busy_t1"}, 32'(busy), 32'd1);
    check_eq({tag, ".valid_t1"}, 32'(valid), 32'd0);
    lat = 0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clock);
      req = 1'b0;
      if (valid) begin
        lat = c;
        break;
      end
      rng_in = (c - 2 < 16) ? seq[c - 2] : 16'($urandom);
      if (poke_req && c == 2) req = 1'b1;
    end
    req = 1'b0;
    check_eq({tag, ".latency"}, 32'(lat), 32'(m_lat));
    check_eq({tag, ".value"}, 32'(value), 32'(m_value));
    check_eq({tag, ".err"}, 32'(err), 32'(m_err));
    check_eq({tag, ".tries"}, 32'(tries), 32'(m_tries));
    hold_cycles = $urandom_range(0, 2);
    for (int k = 0; k < hold_cycles; k++) begin
      @(negedge clock);
      rng_in = 16'($urandom);
      check_eq({tag, ".hold_value"}, 32'(value), 32'(m_value));
      check_eq({tag, ".hold_valid"}, 32'(valid), 32'd1);
    end
    ack = 1'b1;
    if (ack_req) begin
      req = 1'b1; lo = 16'd1; hi = 16'd9;
    end
    @(negedge clock);
    ack = 1'b0; req = 1'b0;
    check_eq({tag, ".valid_after_ack"}, 32'(valid), 32'd0);
    check_eq({tag, ".busy_after_ack"}, 32'(busy), 32'd0);
    check_eq({tag, ".value_after_ack"}, 32'(value), 32'(m_value));
  endtask

  initial begin
    logic [15:0] l, h;
    int kind;
    reset = 1'b1; req = 1'b0; ack = 1'b0; lo = 16'd0; hi = 16'd0; rng_in = 16'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_eq("reset.busy", 32'(busy), 32'd0);
    check_eq("reset.valid", 32'(valid), 32'd0);
    check_eq("reset.value", 32'(value), 32'd0);
    check_eq("reset.err", 32'(err), 32'd0);
    check_eq("reset.tries", 32'(tries), 32'd0);

    fill_seq(16'h0005);
    run_txn("accept", 16'd10, 16'd17, 1'b0, 1'b0);

    fill_seq(16'd2); seq[0] = 16'd6; seq[1] = 16'd7;
    run_txn("reject2", 16'd0, 16'd4, 1'b0, 1'b0);

    fill_seq(16'h0007);
    run_txn("fallback", 16'd100, 16'd104, 1'b0, 1'b0);

    run_txn("degenerate", 16'h1234, 16'h1234, 1'b0, 1'b0);
    run_txn("error", 16'd50, 16'd20, 1'b0, 1'b0);

    fill_seq(16'hBEEF);
    run_txn("full", 16'd0, 16'hFFFF, 1'b0, 1'b0);

    fill_seq(16'd7); seq[2] = 16'd1;
    run_txn("poke_req", 16'd0, 16'd4, 1'b1, 1'b0);

    fill_seq(16'd3);
    run_txn("ack_req", 16'd20, 16'd25, 1'b0, 1'b1);
    @(negedge clock);
    check_eq("ack_req.still_idle", 32'(busy), 32'd0);

    l = value;
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    check_eq("idle_ack.busy", 32'(busy), 32'd0);
    check_eq("idle_ack.valid", 32'(valid), 32'd0);
    check_eq("idle_ack.value", 32'(value), 32'(l));

    // Reset while DRAW keeps rejecting (mask 3, cand 3 > 2)
    @(negedge clock);
    req = 1'b1; lo = 16'd0; hi = 16'd2; rng_in = 16'd3;
    @(negedge clock);
    req = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_draw.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("rst_draw.busy", 32'(busy), 32'd0);
    check_eq("rst_draw.valid", 32'(valid), 32'd0);
    check_eq("rst_draw.value", 32'(value), 32'd0);
    check_eq("rst_draw.err", 32'(err), 32'd0);
    check_eq("rst_draw.tries", 32'(tries), 32'd0);
    fill_seq(16'd3); seq[1] = 16'd1;
    run_txn("after_reset", 16'd0, 16'd2, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      l = 16'($urandom);
      if (kind == 0)      h = l;
      else if (kind == 1) begin h = 16'($urandom); if (h >= l) begin h = l; l = l + 16'd1; end end
      else if (kind == 2) h = l + 16'($urandom);
      else                h = l + 16'($urandom_range(1, 300));
      for (int i = 0; i < 16; i++) seq[i] = 16'($urandom);
      run_txn("random", l, h, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_range.md
# rng_range

Bounded random-number stage that sits directly downstream of the 16-bit LFSR random generator. It consumes the free-running `rng_out` stream and, on request, returns one uniformly distributed value in an inclusive range `[lo, hi]`. Rejection sampling against a power-of-two mask preserves uniformity, and a modulo-style fallback bounds the worst-case latency. Game and control logic use it wherever a bounded random value is needed, for example a card index, a delay, or a coordinate.

## Interface
- `MAX_TRIES`, default 8: number of DRAW cycles before the fallback path is forced. Legal range is 1–15.
- `clock` input, 1 bit: single clock; all logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `rng_in` input, 16 bits: LFSR output. It is assumed to change every cycle and is sampled only in DRAW.
- `req` input, 1 bit: request strobe. It is accepted only in IDLE.
- `lo` input, 16 bits: lower bound, inclusive. It is captured on an accepted `req`.
- `hi` input, 16 bits: upper bound, inclusive. It is captured on an accepted `req`.
- `ack` input, 1 bit: consumer acknowledge. It is honoured only while `valid` = 1.
- `busy` output, 1 bit: high in every state except IDLE.
- `valid` output, 1 bit: result available. It holds until acknowledged.
- `value` output, 16 bits: result. It is stable while `valid` = 1.
- `err` output, 1 bit: the captured request had `hi` < `lo`. It is valid while `valid` = 1.
- `tries` output, 4 bits: number of rejected draws for the current result. It is valid while `valid` = 1.

## Operation
- **States:** IDLE, MASK, DRAW, HOLD.
- **IDLE, on `req` = 1:**
  - Latch `lo` into `lo_r`.
  - Compute `range_r = hi - lo` (16-bit, wrapping).
  - Latch `err_r = (hi < lo)`, unsigned compare.
  - Clear the try counter, then go to MASK.
- **MASK:**
  - `mask_r` is set to the smear of `range_r`: `r | r>>1 | r>>2 | r>>4 | r>>8`. This gives the smallest 2^k−1 that is ≥ `range_r`.
  - Next state depends on the captured request:
    - If `err_r` = 1: `value` = `lo_r`, go to HOLD.
    - Else if `range_r` = 0: `value` = `lo_r`, go to HOLD.
    - Otherwise go to DRAW.
- **DRAW, each cycle:** compute `cand = rng_in & mask_r`.
  - **Accept:** if `cand <= range_r`, then `value = lo_r + cand` (16-bit, no overflow possible), then go to HOLD.
  - **Reject, budget left:** if `cand > range_r` and the try counter is below `MAX_TRIES−1`, increment the counter and stay in DRAW.
  - **Reject, budget exhausted:** if `cand > range_r` and the try counter equals `MAX_TRIES−1`, apply the fallback:
    - `value = lo_r + (cand − range_r − 1)`. The `cand − range_r − 1` term is always < `range_r + 1` because `cand` ≤ 2·`range_r` + 1.
    - Increment the counter, then go to HOLD.
- **HOLD:**
  - `valid` = 1; `value`, `err` and `tries` are frozen.
  - On `ack` = 1, go to IDLE.
- **Ignored inputs:**
  - `req` outside IDLE is ignored and not queued. This includes `req` in the same cycle as `ack`; the requester must re-assert.
  - `ack` outside HOLD is ignored.
- **Full range** (`lo` = 0, `hi` = 0xFFFF): `mask_r` = 0xFFFF, so every draw is accepted.

## Timing
- **Reset values:** `busy` = 0, `valid` = 0, `value` = 0, `err` = 0, `tries` = 0; state is IDLE.
- **Reset mid-operation:** the current request is abandoned. Outputs return to reset values on the next edge, and no result is produced.
- **Latency:** with `req` sampled at edge T:
  - `busy` = 1 from T+1.
  - MASK occupies T+1.
  - DRAW first occurs at T+2.
  - Best-case `valid` = 1 at T+3.
  - Each rejection adds one cycle.
  - Worst case `valid` = 1 at T+2+`MAX_TRIES`.
- **Degenerate and error cases:** `range_r` = 0 or `err_r` = 1 gives `valid` at T+2.
- **Handshake completion:** `ack` sampled at edge A in HOLD gives `valid` = 0 and `busy` = 0 at A+1. A new `req` is accepted no earlier than A+1.
- **Output timing:** `value`, `err` and `tries` change only on entry to HOLD or on reset.

## Test plan
- **Reset during DRAW.** Stimulus: `lo` = 0, `hi` = 2, `rng_in` held at 3 so every draw rejects; assert `reset` while in DRAW. Required: all outputs are 0 on the next cycle, state is IDLE, and a following `req` behaves normally.
- **Immediate accept.** Stimulus: `lo` = 10, `hi` = 17, `rng_in` = 0x0005, `req` at T. Required: `mask_r` = 7; `valid` at T+3 with `value` = 15, `tries` = 0, `err` = 0; `value` holds until `ack`.
- **Rejection then accept.** Stimulus: `lo` = 0, `hi` = 4 (`mask_r` = 7), `rng_in` = 6, 7, 2 on successive DRAW cycles. Required: `valid` at T+5 with `value` = 2, `tries` = 2.
- **Fallback path.** Stimulus: `MAX_TRIES` = 8, `lo` = 100, `hi` = 104, `rng_in` held at 0x0007. Required: `valid` at T+10, `value` = 100 + (7−4−1) = 102, `tries` = 8.
- **Degenerate and error requests.** Stimulus: (a) `lo` = `hi` = 0x1234; (b) `lo` = 50, `hi` = 20. Required: both give `valid` at T+2 with `value` = `lo`; `err` = 0 in case (a) and `err` = 1 in case (b).
- **Handshake corner cases.**
  - `req` pulsed during DRAW: ignored.
  - `ack` and `req` in the same HOLD cycle: return to IDLE, no new request started.
  - `ack` pulsed while IDLE: no effect.
  - Full range `lo` = 0, `hi` = 0xFFFF with `rng_in` = 0xBEEF: `value` = 0xBEEF at T+3.
